uart_rx_mmio: RTL
=================

Name: uart_rx_mmio

Overview:
Memory-mapped serial input port: the read-side counterpart to the MEM stage's memory-mapped screen output.
- Deserialises an 8N1 UART line into bytes and buffers them in a small FIFO.
- Exposes a data register and a status register that MEM-stage loads read in the I/O address window.
- Sits beside DM on the MEM stage. Read data is combinational, so it lands in the WB pipeline register in the same cycle as a DM load.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 4
FIFO_DEPTH, 8, receive FIFO entries; power of two
PTR_W, 3, log2(FIFO_DEPTH)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
rd_en  input  1  load strobe: memRead qualified by the I/O address decode
sel  input  1  register select (EXout[2]): 0 = DATA, 1 = STATUS
Dout  output  32  read data, combinational from sel and state
irq  output  1  high while FIFO is non-empty

Behaviour:
Reset:
- rst low asynchronously forces: FSM to IDLE, FIFO pointers and count to 0, overrun and frame_err to 0, both rx synchroniser flops to 1, bit counter and shift register to 0.
- irq = 0 during reset; Dout reads 0 (STATUS = 0, DATA empty).
- Reset mid-frame discards the partial byte.

Input sync:
- rx passes through 2 flops (rx_s); the FSM uses only rx_s.

FSM (baud counter cnt, bit index bi):
- IDLE: rx_s == 0 -> START, cnt = CLKS_PER_BIT/2 - 1.
- START: decrement cnt. At 0, sample rx_s:
  - 0 -> DATA, cnt = CLKS_PER_BIT - 1, bi = 0.
  - 1 -> IDLE (glitch rejected, nothing pushed).
- DATA: at cnt == 0, shift rx_s in LSB-first and reload cnt. After bit 7 -> STOP.
- STOP: at cnt == 0, sample rx_s:
  - 1 -> push byte.
  - 0 -> set frame_err, discard byte.
  - Either way -> IDLE on the next cycle. A new start bit can be detected immediately (no full stop-bit wait).

FIFO:
- Push occurs on the stop-sample edge. The byte is visible in DATA and irq rises the following cycle.
- Pop occurs at the posedge when rd_en & !sel & count != 0.
- Push when full and no same-cycle pop: byte dropped, overrun set.
- Simultaneous push and pop when full: both happen, count unchanged, no overrun.
- Simultaneous push and pop when empty: the pop is ignored (DATA read returns 0), push occurs.
- Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.

Registers:
- DATA (sel = 0): {24'b0, head byte}; 32'h0 when empty.
- STATUS (sel = 1): {26'b0, count[PTR_W:0] zero-extended to 4 bits in [5:2]... } is not used; the fixed layout is:
  - [0] not_empty
  - [1] full
  - [2] frame_err
  - [3] overrun
  - [7:4] count (saturates in 4 bits)
  - all other bits 0.
- A STATUS read (rd_en & sel) clears frame_err and overrun at that posedge. If a new error occurs in the same cycle, set wins.
- Read side effects are tied only to rd_en. Flushed or bubbled MEM cycles must drive rd_en = 0.

Arithmetic:
- cnt is wide enough for CLKS_PER_BIT - 1.
- Bit timing is derived only from cnt. No oversampling majority vote.

Test Plan:
1. CLKS_PER_BIT = 8, send 0xA5 -> irq rises exactly 1 cycle after the mid-stop sample (start edge + 2 sync + 4 + 8*8 + 8 cycles). STATUS = 0x11. DATA read returns 0x000000A5, then irq = 0 and STATUS = 0x00.
2. Back-to-back 0x00, 0xFF, 0x3C with a 1-bit stop and no gap -> 3 entries in order. STATUS count = 3. Three DATA reads return 0x00, 0xFF, 0x3C.
3. Send 9 bytes without reading -> first 8 retained, STATUS = 0x89 | 0x02 (full, overrun, count 8). A STATUS read clears overrun; the next read shows 0x83.
4. Frame with stop bit held 0 -> no push, frame_err = 1 (STATUS = 0x04). Then a valid 0x55 is received normally.
5. rx low pulse of 2 cycles (< half bit) -> returns to IDLE, FIFO unchanged. DATA read on empty FIFO returns 0 with no pointer change.
6. rst low mid DATA state, then release and send 0x7E -> only 0x7E is received, no error flags. Full FIFO plus a read coinciding with the 9th stop sample -> count stays 8, overrun stays 0.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a small FIFO, read through DATA/STATUS registers.
// Ports: clk, rst (async active-low), rx (serial line, idle high),
//   rd_en (I/O load strobe), sel (0 = DATA, 1 = STATUS),
//   Dout (combinational read data), irq (FIFO non-empty).
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int PTR_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        rd_en,
    input  logic        sel,
    output logic [31:0] Dout,
    output logic        irq
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bi, bi_n;
    logic [7:0]       shift, shift_n;
    logic             rx_q1, rx_s;
    logic             push, ferr_set;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             frame_err, overrun;
    logic             not_empty, full, pop, push_ok, ovr_set, st_rd;
    logic [3:0]       cnt4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
            state <= S_IDLE;
            cnt   <= '0;
            bi    <= '0;
            shift <= '0;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
            state <= state_n;
            cnt   <= cnt_n;
            bi    <= bi_n;
            shift <= shift_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bi_n     = bi;
        shift_n  = shift;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = HALF;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        state_n = S_DATA;
                        cnt_n   = FULL;
                        bi_n    = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shift_n = {rx_s, shift[7:1]};
                    cnt_n   = FULL;
                    if (bi == 3'd7) state_n = S_STOP;
                    else            bi_n    = bi + 3'd1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == '0) begin
                    state_n  = S_IDLE;
                    push     = rx_s;
                    ferr_set = !rx_s;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign not_empty = (count != '0);
    assign full      = (count == DEPTH);
    assign pop       = rd_en & !sel & not_empty;
    // A full FIFO still accepts a byte when the same edge frees a slot.
    assign push_ok   = push & (!full | pop);
    assign ovr_set   = push & full & !pop;
    assign st_rd     = rd_en & sel;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            // Set beats the clear-on-read of the same edge.
            frame_err <= ferr_set | (frame_err & !st_rd);
            overrun   <= ovr_set | (overrun & !st_rd);
        end
    end

    generate
        if (PTR_W + 1 > 4) begin : g_sat
            assign cnt4 = (|count[PTR_W:4]) ? 4'hF : count[3:0];
        end else begin : g_ext
            assign cnt4 = 4'(count);
        end
    endgenerate

    assign irq = not_empty;

    always_comb begin
        Dout = '0;
        if (sel) begin
            Dout[0]   = not_empty;
            Dout[1]   = full;
            Dout[2]   = frame_err;
            Dout[3]   = overrun;
            Dout[7:4] = cnt4;
        end else if (not_empty) begin
            Dout[7:0] = mem[rd_ptr];
        end
    end

endmodule
